pseudo_spi_xfer: RTL

Parametrised successor to the single-direction pseudo-SPI output block. Streams DATA_LEN words from SRAM to the analog device bit by bit on two non-overlapping clocks (SCLK1/SCLK2), then pulses LAT. Adds a programmable clock divider, selectable bit order, and an optional readback mode that captures SPI_SI and writes the captured words back to SRAM. Sits between the CPU-side SRAM port and the analog scan chain.

---
 rtl/pseudo_spi_xfer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pseudo_spi_xfer.sv
// pseudo_spi_xfer: streams DATA_LEN words read from SRAM out to an analog scan
// chain one bit at a time on two non-overlapping shift clocks, then strobes LAT.
// Optionally captures SPI_SI during the shift and writes the captured words back.
//
// Ports:
//   CLK, RST_N        system clock (rising edge), asynchronous active-low reset
//   START             1-cycle request, ignored while BUSY
//   ADDR_BGN          first source address
//   RB_ADDR_BGN       first readback destination address
//   DATA_LEN          number of words to transfer (0 = no transfer, just DONE)
//   FREQ_DIV          each clock phase lasts FREQ_DIV+1 cycles
//   MSB_FIRST         bit order of both SPI_SO and the SPI_SI capture
//   RD_EN             enable readback capture and SRAM write-back
//   SPI_SI            serial data from device
//   PI                SRAM read data (valid one cycle after the read request)
//   SCLK1, SCLK2      non-overlapping shift clocks
//   LAT               latch strobe, 2*(FREQ_DIV+1) cycles after the last word
//   SPI_SO            serial data to device
//   A, CEN, D_WE, DO  SRAM address, enable (low), write enable (low), write data
//   BUSY, DONE        transfer in progress, 1-cycle completion pulse
module pseudo_spi_xfer #(
  parameter int unsigned MEMORY_DATA_WIDTH = 8,
  parameter int unsigned MEMORY_ADDR_WIDTH = 9,
  parameter int unsigned RESERVED_DATA_LEN = 8,
  parameter int unsigned DIV_WIDTH         = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         START,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] RB_ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic [DIV_WIDTH-1:0]         FREQ_DIV,
  input  logic                         MSB_FIRST,
  input  logic                         RD_EN,
  input  logic                         SPI_SI,
  input  logic [MEMORY_DATA_WIDTH-1:0] PI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         LAT,
  output logic                         SPI_SO,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic                         CEN,
  output logic                         D_WE,
  output logic [MEMORY_DATA_WIDTH-1:0] DO,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int unsigned DW = MEMORY_DATA_WIDTH;
  localparam int unsigned AW = MEMORY_ADDR_WIDTH;
  localparam int unsigned LW = RESERVED_DATA_LEN;
  localparam int unsigned VW = DIV_WIDTH;
  localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [BW-1:0] LastBit = BW'(DW - 1);
  localparam logic [LW-1:0] LenOne  = LW'(1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRdReq = 3'd1;
  localparam logic [2:0] StRdCap = 3'd2;
  localparam logic [2:0] StShift = 3'd3;
  localparam logic [2:0] StWr    = 3'd4;
  localparam logic [2:0] StNext  = 3'd5;
  localparam logic [2:0] StLatch = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic [VW-1:0] div_q, div_d;
  logic          msb_q, msb_d;
  logic          rd_en_q, rd_en_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [DW-1:0] cap_q, cap_d;
  logic [1:0]    phase_q, phase_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  // One bit wider than FREQ_DIV so the LATCH phase can count 2*(FREQ_DIV+1).
  logic [VW:0]   tick_q, tick_d;

  logic          sclk1_q, sclk1_d, sclk2_q, sclk2_d, lat_q, lat_d, so_q, so_d;
  logic          cen_q, cen_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] do_q, do_d;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    wb_addr_d   = wb_addr_q;
    remaining_d = remaining_q;
    div_d       = div_q;
    msb_d       = msb_q;
    rd_en_d     = rd_en_q;
    shreg_d     = shreg_q;
    cap_d       = cap_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    tick_d      = tick_q;

    case (state_q)
      StIdle: begin
        if (START) begin
          rd_addr_d   = ADDR_BGN;
          wb_addr_d   = RB_ADDR_BGN;
          remaining_d = DATA_LEN;
          div_d       = FREQ_DIV;
          msb_d       = MSB_FIRST;
          rd_en_d     = RD_EN;
          state_d     = (DATA_LEN == '0) ? StDone : StRdReq;
        end
      end
      StRdReq: state_d = StRdCap;
      StRdCap: begin
        shreg_d   = PI;
        phase_d   = 2'd0;
        tick_d    = '0;
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        if (tick_q == {1'b0, div_q}) begin
          tick_d  = '0;
          phase_d = phase_q + 2'd1;
          // Capture on the last cycle of the SCLK1 phase, same order as SPI_SO.
          if (phase_q == 2'd1) begin
            cap_d = msb_q ? {cap_q[DW-2:0], SPI_SI} : {SPI_SI, cap_q[DW-1:1]};
          end
          if (phase_q == 2'd3) begin
            shreg_d   = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) begin
              state_d = rd_en_q ? StWr : StNext;
            end
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StWr: begin
        wb_addr_d = wb_addr_q + 1'b1;
        state_d   = StNext;
      end
      StNext: begin
        rd_addr_d   = rd_addr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        tick_d      = '0;
        state_d     = (remaining_q != LenOne) ? StRdReq : StLatch;
      end
      StLatch: begin
        // {div,1} == 2*(div+1)-1: last cycle of the latch pulse.
        if (tick_q == {div_q, 1'b1}) begin
          state_d = StDone;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are computed from the next state and registered with it, so they
    // change cleanly on the clock edge that enters each state.
    sclk1_d = (state_d == StShift) && (phase_d == 2'd1);
    sclk2_d = (state_d == StShift) && (phase_d == 2'd3);
    so_d    = (state_d == StShift) && (msb_d ? shreg_d[DW-1] : shreg_d[0]);
    lat_d   = (state_d == StLatch);
    cen_d   = !((state_d == StRdReq) || (state_d == StWr));
    we_d    = (state_d != StWr);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    a_d     = a_q;
    if (state_d == StRdReq) begin
      a_d = rd_addr_d;
    end else if (state_d == StWr) begin
      a_d = wb_addr_d;
    end
    do_d = (state_d == StWr) ? cap_d : do_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      wb_addr_q   <= '0;
      remaining_q <= '0;
      div_q       <= '0;
      msb_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      shreg_q     <= '0;
      cap_q       <= '0;
      phase_q     <= 2'd0;
      bit_cnt_q   <= '0;
      tick_q      <= '0;
      sclk1_q     <= 1'b0;
      sclk2_q     <= 1'b0;
      lat_q       <= 1'b0;
      so_q        <= 1'b0;
      cen_q       <= 1'b1;
      we_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      a_q         <= '0;
      do_q        <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      wb_addr_q   <= wb_addr_d;
      remaining_q <= remaining_d;
      div_q       <= div_d;
      msb_q       <= msb_d;
      rd_en_q     <= rd_en_d;
      shreg_q     <= shreg_d;
      cap_q       <= cap_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      tick_q      <= tick_d;
      sclk1_q     <= sclk1_d;
      sclk2_q     <= sclk2_d;
      lat_q       <= lat_d;
      so_q        <= so_d;
      cen_q       <= cen_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      a_q         <= a_d;
      do_q        <= do_d;
    end
  end

  assign SCLK1  = sclk1_q;
  assign SCLK2  = sclk2_q;
  assign LAT    = lat_q;
  assign SPI_SO = so_q;
  assign A      = a_q;
  assign CEN    = cen_q;
  assign D_WE   = we_q;
  assign DO     = do_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule
